// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter with one-byte holding buffer and line-break generation
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   dataIn         byte to send (bits above the configured width are ignored)
//   sendData       one-cycle strobe presenting dataIn
//   dataBits       data bit count minus 5
//   hasParity      append a parity bit
//   parityMode     00 space, 11 mark, 10 even, 01 odd
//   extraStopBit   two stop bits instead of one
//   clockDivisor   bit period T = 2*(clockDivisor+1) clk cycles
//   sendBreak      level request to hold the line low
//   clearOverflow  clears the sticky overflow flag
//   tx             registered serial output, idle high
//   busy           frame, break or post-break mark in progress
//   bufferFull     holding register contains an unsent byte
//   overflow       sticky flag: a byte was dropped

module uart_transmitter #(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     dataIn,
    input  logic                           sendData,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    input  logic                           sendBreak,
    input  logic                           clearOverflow,
    output logic                           tx,
    output logic                           busy,
    output logic                           bufferFull,
    output logic                           overflow
);

    localparam int TW = CLOCK_DIVISOR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        BREAK_MARK
    } stateT;

    stateT                          state;
    stateT                          stateNext;
    logic [TW-1:0]                  timer;
    logic [2:0]                     bitCount;
    logic [7:0]                     shiftReg;
    logic                           parityBit;
    logic [7:0]                     bufferReg;

    // Frame configuration captured when a frame (or break) begins
    logic [1:0]                     cfgDataBits;
    logic                           cfgHasParity;
    logic                           cfgExtraStop;
    logic [CLOCK_DIVISOR_WIDTH-1:0] cfgDivisor;

    logic          timerDone;
    logic          lastDataBit;
    logic          lastStopBit;
    logic          startFrame;
    logic          fromBuffer;
    logic          latchCfg;
    logic          storeByte;
    logic          dropByte;
    logic [7:0]    loadByte;
    logic [7:0]    dataMask;
    logic          dataXor;
    logic          parityNext;
    logic          txNext;

    // Last cycle of a bit: T-1 = 2*clockDivisor+1, which fits the timer at the maximum divisor
    assign timerDone   = (timer == {cfgDivisor, 1'b1});
    assign lastDataBit = (bitCount == ({1'b0, cfgDataBits} + 3'd4));
    assign lastStopBit = (bitCount[0] == cfgExtraStop);

    assign loadByte   = fromBuffer ? bufferReg : dataIn;
    assign dataMask   = 8'hFF >> (2'd3 - dataBits);
    assign dataXor    = ^(loadByte & dataMask);

    always_comb begin
        parityNext = 1'b0;
        case (parityMode)
            2'b00:   parityNext = 1'b0;
            2'b11:   parityNext = 1'b1;
            2'b10:   parityNext = dataXor;
            default: parityNext = ~dataXor;
        endcase
    end

    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        fromBuffer = 1'b0;
        case (state)
            IDLE: begin
                // A byte buffered on the edge that returned us to IDLE goes out first
                if (bufferFull) begin
                    stateNext  = START;
                    startFrame = 1'b1;
                    fromBuffer = 1'b1;
                end else if (sendBreak) begin
                    stateNext = BREAK;
                end else if (sendData) begin
                    stateNext  = START;
                    startFrame = 1'b1;
                end
            end
            START: begin
                if (timerDone) stateNext = DATA;
            end
            DATA: begin
                if (timerDone && lastDataBit) stateNext = cfgHasParity ? PARITY : STOP;
            end
            PARITY: begin
                if (timerDone) stateNext = STOP;
            end
            STOP: begin
                if (timerDone && lastStopBit) begin
                    if (sendBreak) begin
                        stateNext = BREAK;
                    end else if (bufferFull) begin
                        stateNext  = START;
                        startFrame = 1'b1;
                        fromBuffer = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            BREAK: begin
                // Timer saturates at its last count, so this waits at least T
                if (timerDone && !sendBreak) stateNext = BREAK_MARK;
            end
            BREAK_MARK: begin
                if (timerDone) begin
                    if (bufferFull) begin
                        stateNext  = START;
                        startFrame = 1'b1;
                        fromBuffer = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign latchCfg  = startFrame || (stateNext == BREAK && state != BREAK);
    // A strobe that did not start a frame directly goes to the buffer if there is room
    assign storeByte = sendData && !(startFrame && !fromBuffer) && !bufferFull;
    assign dropByte  = sendData && bufferFull;

    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START, BREAK: txNext = 1'b0;
            DATA:         txNext = (state == DATA && timerDone) ? shiftReg[1] : shiftReg[0];
            PARITY:       txNext = parityBit;
            default:      txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            bitCount     <= '0;
            shiftReg     <= '0;
            parityBit    <= 1'b0;
            bufferReg    <= '0;
            bufferFull   <= 1'b0;
            overflow     <= 1'b0;
            tx           <= 1'b1;
            cfgDataBits  <= '0;
            cfgHasParity <= 1'b0;
            cfgExtraStop <= 1'b0;
            cfgDivisor   <= '0;
        end else begin
            state <= stateNext;
            tx    <= txNext;

            if (stateNext != state || state == IDLE) begin
                timer <= '0;
            end else if (timerDone) begin
                timer <= (state == BREAK) ? timer : '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (stateNext != state) begin
                bitCount <= '0;
            end else if (timerDone && (state == DATA || state == STOP)) begin
                bitCount <= bitCount + 3'd1;
            end

            if (startFrame) begin
                shiftReg  <= loadByte;
                parityBit <= parityNext;
            end else if (state == DATA && timerDone) begin
                shiftReg <= {1'b0, shiftReg[7:1]};
            end

            if (latchCfg) begin
                cfgDataBits  <= dataBits;
                cfgHasParity <= hasParity;
                cfgExtraStop <= extraStopBit;
                cfgDivisor   <= clockDivisor;
            end

            if (storeByte) begin
                bufferReg <= dataIn;
            end

            if (startFrame && fromBuffer) begin
                bufferFull <= 1'b0;
            end else if (storeByte) begin
                bufferFull <= 1'b1;
            end

            if (dropByte) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard testbench for uart_transmitter

module tb_uart_transmitter;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   dataIn = 8'h00;
    logic         sendData = 1'b0;
    logic [1:0]   dataBits = 2'd3;
    logic         hasParity = 1'b0;
    logic [1:0]   parityMode = 2'b00;
    logic         extraStopBit = 1'b0;
    logic [W-1:0] clockDivisor = 24'd1;
    logic         sendBreak = 1'b0;
    logic         clearOverflow = 1'b0;
    logic         tx;
    logic         busy;
    logic         bufferFull;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;      // 0 frame, 1 break
        int          nBits;
        logic [15:0] bits;
        int          period;
        int          lowLen;
        int          highLen;
        bit          gapless;
        bit          endIdle;
    } expT;

    expT expQ[$];
    bit  bypass  = 1'b0;
    bit  monBusy = 1'b0;

    uart_transmitter #(.CLOCK_DIVISOR_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dataIn       (dataIn),
        .sendData     (sendData),
        .dataBits     (dataBits),
        .hasParity    (hasParity),
        .parityMode   (parityMode),
        .extraStopBit (extraStopBit),
        .clockDivisor (clockDivisor),
        .sendBreak    (sendBreak),
        .clearOverflow(clearOverflow),
        .tx           (tx),
        .busy         (busy),
        .bufferFull   (bufferFull),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame: start bit, data LSB first, optional parity, stop bit(s)
    function automatic expT mkFrame(input logic [7:0] d, input int db, input bit hp,
                                    input logic [1:0] pm, input bit es, input int div,
                                    input bit gapless, input bit endIdle);
        expT  e;
        int   n;
        logic ones;
        e.kind = 0;
        e.bits = '0;
        n = 0;
        ones = 1'b0;
        e.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < db + 5; i++) begin
            e.bits[n] = d[i];
            ones ^= d[i];
            n++;
        end
        if (hp) begin
            case (pm)
                2'b00:   e.bits[n] = 1'b0;
                2'b11:   e.bits[n] = 1'b1;
                2'b10:   e.bits[n] = ones;
                default: e.bits[n] = ~ones;
            endcase
            n++;
        end
        e.bits[n] = 1'b1;
        n++;
        if (es) begin
            e.bits[n] = 1'b1;
            n++;
        end
        e.nBits   = n;
        e.period  = 2 * (div + 1);
        e.lowLen  = 0;
        e.highLen = 0;
        e.gapless = gapless;
        e.endIdle = endIdle;
        return e;
    endfunction

    function automatic expT mkBreak(input int lowLen, input int highLen);
        expT e;
        e.kind    = 1;
        e.nBits   = 0;
        e.bits    = '0;
        e.period  = 0;
        e.lowLen  = lowLen;
        e.highLen = highLen;
        e.gapless = 1'b1;
        e.endIdle = 1'b1;
        return e;
    endfunction

    task automatic configure(input logic [1:0] db, input logic hp, input logic [1:0] pm,
                             input logic es, input int div);
        dataBits     = db;
        hasParity    = hp;
        parityMode   = pm;
        extraStopBit = es;
        clockDivisor = W'(div);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        dataIn   = d;
        sendData = 1'b1;
        @(negedge clk);
        sendData = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || monBusy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 20000), 1);
    endtask

    // Monitor: decodes the line and compares against the scoreboard queue
    initial begin
        int  idleCnt;
        int  bad;
        int  cnt;
        expT e;
        idleCnt = 0;
        forever begin
            @(negedge clk);
            if (rst || bypass) begin
                idleCnt = 0;
            end else if (tx === 1'b1) begin
                idleCnt++;
            end else begin
                monBusy = 1'b1;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedStart actual=tx_low required=idle at %0t", $time);
                    cnt = 0;
                    while (tx !== 1'b1 && cnt < 1000) begin
                        @(negedge clk);
                        cnt++;
                    end
                end else begin
                    e = expQ.pop_front();
                    if (e.gapless) check("gapBefore", idleCnt, 0);
                    if (e.kind == 0) begin
                        bad = 0;
                        for (int k = 0; k < e.nBits * e.period; k++) begin
                            if (k > 0) @(negedge clk);
                            if (tx !== e.bits[k / e.period] || busy !== 1'b1) bad++;
                        end
                        check("frameBits", bad, 0);
                        if (e.endIdle) begin
                            @(negedge clk);
                            check("idleAfterFrame", {tx, busy}, 2'b10);
                        end
                    end else begin
                        cnt = 0;
                        while (tx === 1'b0 && cnt < 100000) begin
                            cnt++;
                            @(negedge clk);
                        end
                        check("breakLow", cnt, e.lowLen);
                        cnt = 0;
                        while (tx === 1'b1 && busy === 1'b1 && cnt < 100000) begin
                            cnt++;
                            @(negedge clk);
                        end
                        check("breakMark", cnt, e.highLen);
                        check("idleAfterBreak", {tx, busy}, 2'b10);
                    end
                end
                idleCnt = 0;
                monBusy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] rdb;
        logic [1:0] rpm;
        logic       rhp;
        logic       res;
        int         rdiv;
        logic [1:0] rdb2;
        logic [1:0] rpm2;
        logic       rhp2;
        logic       res2;
        int         rdiv2;
        int         bad;
        logic [1:0] modes [4];

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("resetTx", tx, 1);
        check("resetBusy", busy, 0);
        check("resetBufferFull", bufferFull, 0);
        check("resetOverflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x55, T = 4
        configure(2'd3, 1'b0, 2'b00, 1'b0, 1);
        expQ.push_back(mkFrame(8'h55, 3, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b1));
        send(8'h55);
        drain("drain8n1");

        // 7-bit 0x41 with each parity mode
        modes[0] = 2'b10;
        modes[1] = 2'b01;
        modes[2] = 2'b00;
        modes[3] = 2'b11;
        for (int m = 0; m < 4; m++) begin
            configure(2'd2, 1'b1, modes[m], 1'b0, 1);
            expQ.push_back(mkFrame(8'h41, 2, 1'b1, modes[m], 1'b0, 1, 1'b0, 1'b1));
            send(8'h41);
            drain("drainParity");
        end

        // 5 bits, two stop bits, upper data bits ignored
        configure(2'd0, 1'b0, 2'b00, 1'b1, 1);
        expQ.push_back(mkFrame(8'hFF, 0, 1'b0, 2'b00, 1'b1, 1, 1'b0, 1'b1));
        send(8'hFF);
        drain("drain5bit");
        configure(2'd0, 1'b0, 2'b00, 1'b1, 0);
        expQ.push_back(mkFrame(8'h15, 0, 1'b0, 2'b00, 1'b1, 0, 1'b0, 1'b1));
        send(8'hF5);
        drain("drain5bitMasked");

        // Back-to-back and overflow
        configure(2'd3, 1'b0, 2'b00, 1'b0, 1);
        expQ.push_back(mkFrame(8'hA5, 3, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b0));
        expQ.push_back(mkFrame(8'h3C, 3, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b1));
        @(negedge clk);
        dataIn   = 8'hA5;
        sendData = 1'b1;
        @(negedge clk);
        dataIn = 8'h3C;
        @(negedge clk);
        check("bufferFullSet", bufferFull, 1);
        check("overflowBeforeDrop", overflow, 0);
        dataIn = 8'h77;
        @(negedge clk);
        sendData = 1'b0;
        check("overflowSet", overflow, 1);
        check("bufferFullAfterDrop", bufferFull, 1);
        drain("drainBackToBack");
        check("overflowSticky", overflow, 1);
        check("bufferEmptyAfter", bufferFull, 0);
        clearOverflow = 1'b1;
        @(negedge clk);
        clearOverflow = 1'b0;
        check("overflowCleared", overflow, 0);

        // Break raised mid-frame, low for 3T, then mark for T
        configure(2'd3, 1'b0, 2'b00, 1'b0, 1);
        expQ.push_back(mkFrame(8'h96, 3, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b0));
        expQ.push_back(mkBreak(12, 4));
        send(8'h96);
        repeat (10) @(negedge clk);
        sendBreak = 1'b1;
        repeat (41) @(negedge clk);
        sendBreak = 1'b0;
        drain("drainBreak");

        // Randomised single frames
        for (int it = 0; it < 8; it++) begin
            rdb  = 2'($urandom_range(0, 3));
            rhp  = 1'($urandom_range(0, 1));
            rpm  = 2'($urandom_range(0, 3));
            res  = 1'($urandom_range(0, 1));
            rdiv = int'($urandom_range(0, 3));
            d1   = 8'($urandom);
            configure(rdb, rhp, rpm, res, rdiv);
            expQ.push_back(mkFrame(d1, int'(rdb), rhp, rpm, res, rdiv, 1'b0, 1'b1));
            send(d1);
            drain("drainRandom");
        end

        // Randomised back-to-back pairs; config changes while the first frame runs
        for (int it = 0; it < 4; it++) begin
            rdb   = 2'($urandom_range(0, 3));
            rhp   = 1'($urandom_range(0, 1));
            rpm   = 2'($urandom_range(0, 3));
            res   = 1'($urandom_range(0, 1));
            rdiv  = int'($urandom_range(0, 3));
            rdb2  = 2'($urandom_range(0, 3));
            rhp2  = 1'($urandom_range(0, 1));
            rpm2  = 2'($urandom_range(0, 3));
            res2  = 1'($urandom_range(0, 1));
            rdiv2 = int'($urandom_range(0, 3));
            d1    = 8'($urandom);
            d2    = 8'($urandom);
            configure(rdb, rhp, rpm, res, rdiv);
            expQ.push_back(mkFrame(d1, int'(rdb), rhp, rpm, res, rdiv, 1'b0, 1'b0));
            expQ.push_back(mkFrame(d2, int'(rdb2), rhp2, rpm2, res2, rdiv2, 1'b1, 1'b1));
            @(negedge clk);
            dataIn   = d1;
            sendData = 1'b1;
            @(negedge clk);
            dataIn = d2;
            @(negedge clk);
            sendData = 1'b0;
            configure(rdb2, rhp2, rpm2, res2, rdiv2);
            drain("drainRandomPair");
        end

        // Reset during data bit 3 with a byte buffered
        bypass = 1'b1;
        configure(2'd3, 1'b0, 2'b00, 1'b0, 1);
        @(negedge clk);
        dataIn   = 8'h12;
        sendData = 1'b1;
        @(negedge clk);
        dataIn = 8'h34;
        @(negedge clk);
        sendData = 1'b0;
        repeat (16) @(negedge clk);
        check("bufferedBeforeReset", bufferFull, 1);
        check("busyBeforeReset", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstTx", tx, 1);
        check("rstBusy", busy, 0);
        check("rstBufferFull", bufferFull, 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("quietAfterReset", bad, 0);
        bypass = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
